// File: rtl/pjon_arb_pkg.sv
// pjon_arb_pkg: shared types and constants for the PJON bus arbiter.
// Holds the arbiter state encoding, requester indices, the backoff LFSR
// tap mask and two small helpers for owner selection.
package pjon_arb_pkg;

    // Arbiter state encoding
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SENSE   = 3'd1,
        BACKOFF = 3'd2,
        GRANT   = 3'd3,
        RELEASE = 3'd4
    } arb_state_e;

    // Requester indices and count
    localparam int unsigned NumReq  = 32'd2;
    localparam int unsigned ReqHw   = 32'd0;
    localparam int unsigned ReqGpio = 32'd1;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
    localparam int unsigned LfsrWidth = 32'd16;
    localparam logic [15:0] LfsrTaps  = 16'hB400;

    // Feedback bit of the backoff LFSR
    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LfsrTaps);
    endfunction

    // Owner selection among the eligible requests; on a tie the requester
    // that was not granted last wins.
    function automatic logic pick_owner(input logic [NumReq-1:0] req,
                                        input logic              last);
        logic win;
        case (req)
            2'b01:   win = 1'(ReqHw);
            2'b10:   win = 1'(ReqGpio);
            2'b11:   win = ~last;
            default: win = 1'(ReqHw);
        endcase
        return win;
    endfunction

    // One-hot grant vector for a requester index
    function automatic logic [NumReq-1:0] owner_onehot(input logic idx);
        logic [NumReq-1:0] oh;
        oh      = 2'b00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pjon_arb_lfsr.sv
// pjon_arb_lfsr: free-running 16-bit Fibonacci LFSR that supplies the
// pseudo-random carrier-sense backoff. Seed must be nonzero, otherwise the
// register locks up at zero.
module pjon_arb_lfsr
    import pjon_arb_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic [LfsrWidth-1:0] lfsr_o
);

    logic [LfsrWidth-1:0] lfsr_r;

    // Advance the LFSR every cycle; shift left, feedback enters at bit 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_r <= Seed;
        end else begin
            lfsr_r <= {lfsr_r[LfsrWidth-2:0], lfsr_feedback(lfsr_r)};
        end
    end

    assign lfsr_o = lfsr_r;

endmodule

// File: rtl/pjon_bus_arbiter.sv
// pjon_bus_arbiter: arbitrates the shared open-drain PJON pad between the
// PJON hardware peripheral (requester 0) and the GPIO bit-bang path
// (requester 1). Ownership is granted only after the line has been idle-low
// for IdleCycles and a backoff count has elapsed; a held grant is forcibly
// released after MaxGrantCycles and the offender is locked out until it
// drops its request.
// Optional feature macro: PJON_ARB_BACKOFF_EN (pseudo-random LFSR backoff;
// when undefined the backoff is always zero and the LFSR is not built).
module pjon_bus_arbiter
    import pjon_arb_pkg::*;
#(
    parameter int unsigned IdleCycles     = 32'd64,
    parameter int unsigned MaxGrantCycles = 32'd1 << 20,
    parameter int unsigned BackoffWidth   = 32'd6,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    input  logic [NumReq-1:0] tx_i,
    input  logic [NumReq-1:0] tx_en_i,
    input  logic              bus_i,
    output logic              bus_o,
    output logic              bus_en_o,
    output logic              rx_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int unsigned     GntW    = $clog2(MaxGrantCycles);
    localparam logic [15:0]     IdleMax = 16'(IdleCycles);
    localparam logic [GntW-1:0] GntLast = GntW'(MaxGrantCycles - 32'd1);

    // Pad synchronizer
    logic sync_q1_r;
    logic sync_q2_r;

    // Carrier sense
    logic [15:0] idle_cnt_r;
    logic        idle_done_s;

    // FSM and bookkeeping
    arb_state_e              state_r;
    arb_state_e              state_s;
    logic [BackoffWidth-1:0] bo_cnt_r;
    logic [BackoffWidth-1:0] bo_cnt_s;
    logic [BackoffWidth-1:0] bo_load_s;
    logic [GntW-1:0]         gnt_cnt_r;
    logic [GntW-1:0]         gnt_cnt_s;
    logic                    owner_r;
    logic                    owner_s;
    logic                    last_r;
    logic                    last_s;
    logic [NumReq-1:0]       lock_r;
    logic [NumReq-1:0]       lock_s;
    logic                    timeout_r;
    logic                    timeout_s;
    logic [NumReq-1:0]       req_eff_s;
    logic                    win_s;

`ifdef PJON_ARB_BACKOFF_EN
    logic [LfsrWidth-1:0] lfsr_s;
    logic                 unused_lfsr_s;

    pjon_arb_lfsr #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lfsr_o (lfsr_s)
    );

    // Backoff count is the low LFSR bits at the moment SENSE completes
    assign bo_load_s     = lfsr_s[BackoffWidth-1:0];
    assign unused_lfsr_s = ^lfsr_s;
`else
    logic unused_cfg_s;

    // Without the LFSR the backoff is always zero: BACKOFF lasts one cycle
    assign bo_load_s    = {BackoffWidth{1'b0}};
    assign unused_cfg_s = ^LfsrSeed;
`endif

    // Two-flop synchronizer for the asynchronous pad input
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q1_r <= 1'b0;
            sync_q2_r <= 1'b0;
        end else begin
            sync_q1_r <= bus_i;
            sync_q2_r <= sync_q1_r;
        end
    end

    assign rx_o = sync_q2_r;

    // Idle-low run length: cleared by any high level, held while we drive
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idle_cnt_r <= 16'd0;
        end else if (sync_q2_r) begin
            idle_cnt_r <= 16'd0;
        end else if (!bus_en_o && (idle_cnt_r != IdleMax)) begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    assign idle_done_s = (idle_cnt_r == IdleMax);

    // Locked-out requesters do not count as pending in SENSE/BACKOFF
    assign req_eff_s = req_i & ~lock_r;
    assign win_s     = pick_owner(req_eff_s, last_r);

    // Next-state logic: carrier sense, backoff, grant and forced release
    always_comb begin
        state_s   = state_r;
        bo_cnt_s  = bo_cnt_r;
        gnt_cnt_s = gnt_cnt_r;
        owner_s   = owner_r;
        last_s    = last_r;
        lock_s    = lock_r & req_i;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req_i) begin
                    state_s = SENSE;
                end else begin
                    state_s = IDLE;
                end
            end
            SENSE: begin
                if (req_eff_s == 2'b00) begin
                    state_s = IDLE;
                end else if (idle_done_s) begin
                    state_s  = BACKOFF;
                    bo_cnt_s = bo_load_s;
                end else begin
                    state_s = SENSE;
                end
            end
            BACKOFF: begin
                if (sync_q2_r) begin
                    state_s = SENSE;
                end else if (req_eff_s == 2'b00) begin
                    state_s = IDLE;
                end else if (bo_cnt_r == {BackoffWidth{1'b0}}) begin
                    state_s   = GRANT;
                    owner_s   = win_s;
                    last_s    = win_s;
                    gnt_cnt_s = {GntW{1'b0}};
                end else begin
                    bo_cnt_s = bo_cnt_r - BackoffWidth'(1'b1);
                end
            end
            GRANT: begin
                if (!req_i[owner_r]) begin
                    state_s = RELEASE;
                end else if (gnt_cnt_r == GntLast) begin
                    state_s         = RELEASE;
                    timeout_s       = 1'b1;
                    lock_s[owner_r] = 1'b1;
                end else begin
                    gnt_cnt_s = gnt_cnt_r + GntW'(1'b1);
                end
            end
            RELEASE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            bo_cnt_r  <= {BackoffWidth{1'b0}};
            gnt_cnt_r <= {GntW{1'b0}};
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            lock_r    <= 2'b00;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            bo_cnt_r  <= bo_cnt_s;
            gnt_cnt_r <= gnt_cnt_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            lock_r    <= lock_s;
            timeout_r <= timeout_s;
        end
    end

    // Pad mux: only the registered owner reaches the pad, and only in GRANT
    always_comb begin
        gnt_o    = 2'b00;
        bus_o    = 1'b0;
        bus_en_o = 1'b0;
        if (state_r == GRANT) begin
            gnt_o    = owner_onehot(owner_r);
            bus_o    = tx_i[owner_r];
            bus_en_o = tx_en_i[owner_r];
        end else begin
            gnt_o    = 2'b00;
            bus_o    = 1'b0;
            bus_en_o = 1'b0;
        end
    end

    assign busy_o    = (state_r != IDLE);
    assign timeout_o = timeout_r;

endmodule
